// File: rtl/statmch_sum3.sv
// statmch_sum3: start/ready sequencer that adds three consecutive samples of d.
// Optional build macro SUM3_SATURATE_EN selects saturating instead of wrap-around adds.
module statmch_sum3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic [WIDTH-1:0] sum
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;

  // Saturation is sticky: once the accumulator is all-ones, adding stays all-ones.
  function automatic logic [WIDTH-1:0] add_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
`ifdef SUM3_SATURATE_EN
    if (t[WIDTH]) begin
      return {WIDTH{1'b1}};
    end else begin
      return t[WIDTH-1:0];
    end
`else
    return t[WIDTH-1:0];
`endif
  endfunction

  // Sequencer: accept start, accumulate three operands, publish the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      sum     <= {WIDTH{1'b0}};
      ready   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            acc_r   <= {WIDTH{1'b0}};
            state_r <= S1;
          end else begin
            state_r <= IDLE;
          end
        end
        S1: begin
          acc_r   <= d;
          state_r <= S2;
        end
        S2: begin
          acc_r   <= add_f(acc_r, d);
          state_r <= S3;
        end
        S3: begin
          sum     <= add_f(acc_r, d);
          ready   <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (start) begin
            ready   <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            state_r <= S1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          ready   <= 1'b0;
          acc_r   <= {WIDTH{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_statmch_sum3.sv
// Scoreboard bench for statmch_sum3: expected results queued at issue, checked on ready rise.
module tb_statmch_sum3;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] d;
  logic       ready;
  logic [7:0] sum;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  logic       ready_q    = 1'b0;
  logic [7:0] last_sum   = 8'h00;

  statmch_sum3 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .d     (d),
    .ready (ready),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising ready must match the oldest queued result and its cycle.
  always @(negedge clk) begin
    if (ready && !ready_q) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got sum %0h, expected no result", sum);
      end else begin
        chk("result_sum", {24'd0, sum}, {24'd0, sb[0].val});
        chk("result_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
    ready_q <= ready;
  end

  // Called at #1 after a rising edge with the DUT in IDLE or DONE.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] exp, input bit busy_pulse);
    exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    chk("accept_ready_low", {31'd0, ready}, 32'd0);
    chk("accept_sum_held", {24'd0, sum}, {24'd0, last_sum});
    start = 1'b0;
    d = a;
    e.val = exp;
    e.cyc = cyc + 3;
    sb.push_back(e);
    @(posedge clk); #1;
    d = b;
    if (busy_pulse) start = 1'b1;
    @(posedge clk); #1;
    d = c;
    start = 1'b0;
    @(posedge clk); #1;
    d = 8'hA5;
    last_sum = exp;
  endtask

  task automatic hold(input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, ready}, 32'd1);
      chk("hold_sum", {24'd0, sum}, {24'd0, exp});
      d = 8'($urandom_range(255, 0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    d     = 8'h00;
    #12;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, ready}, 32'd0);
    end
    @(posedge clk); #1;

    issue(8'd10, 8'd20, 8'd30, 8'd60, 1'b0);
    hold(8'd60, 3);
    issue(8'd5, 8'd5, 8'd5, 8'd15, 1'b0);
    hold(8'd15, 2);
`ifdef SUM3_SATURATE_EN
    issue(8'd200, 8'd100, 8'd10, 8'd255, 1'b0);
    hold(8'd255, 2);
`else
    issue(8'd200, 8'd100, 8'd10, 8'd54, 1'b0);
    hold(8'd54, 2);
`endif

    // Asynchronous reset asserted mid-cycle while holding a result.
    #3 reset = 1'b1;
    #1;
    chk("async_reset_ready", {31'd0, ready}, 32'd0);
    chk("async_reset_sum", {24'd0, sum}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_sum = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_ready", {31'd0, ready}, 32'd0);
    end
    @(posedge clk); #1;

    issue(8'd1, 8'd2, 8'd3, 8'd6, 1'b1);
    hold(8'd6, 4);

    // Abort in S3: no partial result may surface.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d = 8'd7;
    @(posedge clk); #1;
    d = 8'd8;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_sum = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, ready}, 32'd0);
    end
    @(posedge clk); #1;

`ifdef SUM3_SATURATE_EN
    issue(8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0);
    hold(8'hFF, 2);
`else
    issue(8'hFF, 8'h01, 8'h00, 8'h00, 1'b0);
    hold(8'h00, 2);
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
